// File: rtl/boot_copier_pkg.sv
// Shared definitions for the boot copier and the BIOS instruction controller:
// FSM state type, BIOS opcodes and default bus widths.
package boot_pkg;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 32;

    localparam logic [5:0] HALT = 6'b011000;
    localparam logic [5:0] CKHD = 6'b011101;
    localparam logic [5:0] CKIM = 6'b011110;
    localparam logic [5:0] CKDM = 6'b011111;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } boot_state_t;

endpackage

// File: rtl/boot_copier_if.sv
// Memory-side bus of the boot copier: HD read port plus instruction-memory write port.
interface boot_copier_if
    import boot_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              hd_re;
    logic [ADDR_W-1:0] hd_addr;
    logic [DATA_W-1:0] hd_rdata;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [DATA_W-1:0] im_wdata;

    modport master (
        output hd_re, hd_addr, im_we, im_addr, im_wdata,
        input  hd_rdata
    );

    modport slave (
        input  hd_re, hd_addr, im_we, im_addr, im_wdata,
        output hd_rdata
    );
endinterface

// File: rtl/boot_copier_rd_latency_counter.sv
// Loadable 3-bit down-counter timing the HD read latency; saturates at zero.
module rd_latency_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       dec,
    input  logic [2:0] load_val,
    output logic [2:0] count,
    output logic       zero
);
    always_ff @(posedge clk) begin
        if (reset)
            count <= 3'd0;
        else if (load)
            count <= load_val;
        else if (dec && count != 3'd0)
            count <= count - 3'd1;
    end

    assign zero = (count == 3'd0);
endmodule

// File: rtl/boot_copier.sv
// Boot copier: moves len words from the HD model into instruction memory.
// Optional running checksum of written words under BOOT_COPIER_CHECKSUM_EN.
module boot_copier
    import boot_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int HD_RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   len,
    boot_copier_if.master     mem,
    output logic              busy,
    output logic              done
`ifdef BOOT_COPIER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);
    // state | meaning
    // IDLE  | waiting for start
    // READ  | hd_re strobe at src+idx
    // WAIT  | remaining HD read latency
    // WRITE | im_we at dst+idx with live hd_rdata
    // DONE  | one-cycle done pulse

    localparam logic [ADDR_W:0] ONE       = (ADDR_W+1)'(1);
    localparam logic [2:0]      WAIT_LOAD = 3'(HD_RD_LAT - 1);

    boot_state_t state, state_nxt;

    logic [ADDR_W:0]   idx, idx_nxt, len_q, len_nxt;
    logic [ADDR_W-1:0] src_q, src_nxt, dst_q, dst_nxt;
    logic [ADDR_W-1:0] hd_addr_q, hd_addr_nxt, im_addr_q, im_addr_nxt;
    logic              hd_re_q, hd_re_nxt, im_we_q, im_we_nxt;
    logic              busy_nxt, done_nxt;
    logic [2:0]        cnt;
    logic              cnt_zero, cnt_load, cnt_dec;

    rd_latency_counter u_lat (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (WAIT_LOAD),
        .count    (cnt),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            idx       <= '0;
            len_q     <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            hd_re_q   <= 1'b0;
            hd_addr_q <= '0;
            im_we_q   <= 1'b0;
            im_addr_q <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            len_q     <= len_nxt;
            src_q     <= src_nxt;
            dst_q     <= dst_nxt;
            hd_re_q   <= hd_re_nxt;
            hd_addr_q <= hd_addr_nxt;
            im_we_q   <= im_we_nxt;
            im_addr_q <= im_addr_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (start) state_nxt = (len == '0) ? ST_DONE : ST_READ;
            ST_READ:  state_nxt = (HD_RD_LAT == 1) ? ST_WRITE : ST_WAIT;
            // zero only guards against a stuck WAIT if the counter was never loaded
            ST_WAIT:  if (cnt == 3'd1 || cnt_zero) state_nxt = ST_WRITE;
            ST_WRITE: state_nxt = (idx + ONE == len_q) ? ST_DONE : ST_READ;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are computed for the next state and registered, so they line up with it.
    always_comb begin
        src_nxt = src_q;
        dst_nxt = dst_q;
        len_nxt = len_q;
        idx_nxt = idx;
        if (state == ST_IDLE && start) begin
            src_nxt = src_addr;
            dst_nxt = dst_addr;
            len_nxt = len;
            idx_nxt = '0;
        end else if (state == ST_WRITE) begin
            idx_nxt = idx + ONE;
        end

        hd_re_nxt   = (state_nxt == ST_READ);
        im_we_nxt   = (state_nxt == ST_WRITE);
        busy_nxt    = (state_nxt == ST_READ) || (state_nxt == ST_WAIT) || (state_nxt == ST_WRITE);
        done_nxt    = (state_nxt == ST_DONE);
        hd_addr_nxt = hd_re_nxt ? src_nxt + idx_nxt[ADDR_W-1:0] : hd_addr_q;
        im_addr_nxt = im_we_nxt ? dst_nxt + idx_nxt[ADDR_W-1:0] : im_addr_q;
        cnt_load    = (state == ST_READ) && (state_nxt == ST_WAIT);
        cnt_dec     = (state == ST_WAIT);
    end

    assign mem.hd_re    = hd_re_q;
    assign mem.hd_addr  = hd_addr_q;
    assign mem.im_we    = im_we_q;
    assign mem.im_addr  = im_addr_q;
    // HD data arrives in the WRITE cycle itself, so it is forwarded rather than registered.
    assign mem.im_wdata = im_we_q ? mem.hd_rdata : '0;

`ifdef BOOT_COPIER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q;

    always_ff @(posedge clk) begin
        if (reset)
            sum_q <= '0;
        else if (state == ST_IDLE && start)
            sum_q <= '0;
        else if (state == ST_WRITE)
            sum_q <= sum_q + mem.hd_rdata;
    end

    assign checksum = sum_q;
`endif

endmodule

// File: tb/tb_boot_copier.sv
// Bench for boot_copier: two instances (HD latency 1 and 3) share stimulus and are
// checked against a per-word timing/address/data model derived from the copy rules.
module tb_boot_copier;
    localparam int AW = 12;
    localparam int DW = 32;
    typedef logic [AW-1:0] addr_t;
    typedef logic [AW:0]   len_t;

    logic  clk = 1'b0;
    logic  reset, start, mon_clr;
    addr_t src_addr, dst_addr;
    len_t  len;
    logic  busy1, done1, busy3, done3;
`ifdef BOOT_COPIER_CHECKSUM_EN
    logic [DW-1:0] chk1, chk3;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    boot_copier_if #(.ADDR_W(AW), .DATA_W(DW)) m1 ();
    boot_copier_if #(.ADDR_W(AW), .DATA_W(DW)) m3 ();

    boot_copier #(.ADDR_W(AW), .DATA_W(DW), .HD_RD_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
        .len(len), .mem(m1), .busy(busy1), .done(done1)
`ifdef BOOT_COPIER_CHECKSUM_EN
        , .checksum(chk1)
`endif
    );

    boot_copier #(.ADDR_W(AW), .DATA_W(DW), .HD_RD_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
        .len(len), .mem(m3), .busy(busy3), .done(done3)
`ifdef BOOT_COPIER_CHECKSUM_EN
        , .checksum(chk3)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // HD model: data appears LAT cycles after the cycle in which hd_re is high
    logic [DW-1:0] hd_mem [0:4095];
    logic [DW-1:0] p1;
    logic [DW-1:0] p3 [0:2];
    always @(posedge clk) begin
        p1    <= (m1.hd_re === 1'b1) ? hd_mem[m1.hd_addr] : $urandom;
        p3[0] <= (m3.hd_re === 1'b1) ? hd_mem[m3.hd_addr] : $urandom;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign m1.hd_rdata = p1;
    assign m3.hd_rdata = p3[2];

    logic          mon_we [2], mon_re [2], mon_busy [2], mon_done [2];
    addr_t         mon_waddr [2], mon_raddr [2];
    logic [DW-1:0] mon_wdata [2];
    assign mon_we[0] = m1.im_we;     assign mon_we[1] = m3.im_we;
    assign mon_re[0] = m1.hd_re;     assign mon_re[1] = m3.hd_re;
    assign mon_busy[0] = busy1;      assign mon_busy[1] = busy3;
    assign mon_done[0] = done1;      assign mon_done[1] = done3;
    assign mon_waddr[0] = m1.im_addr; assign mon_waddr[1] = m3.im_addr;
    assign mon_raddr[0] = m1.hd_addr; assign mon_raddr[1] = m3.hd_addr;
    assign mon_wdata[0] = m1.im_wdata; assign mon_wdata[1] = m3.im_wdata;

    int            wr_n [2], rd_n [2], done_n [2], busy_n [2], ovl_n [2], done_cyc [2];
    int            wr_cyc [2][64], rd_cyc [2][64];
    addr_t         wr_addr [2][64], rd_addr [2][64];
    logic [DW-1:0] wr_data [2][64];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mon_clr) begin
                wr_n[d] <= 0; rd_n[d] <= 0; done_n[d] <= 0;
                busy_n[d] <= 0; ovl_n[d] <= 0; done_cyc[d] <= -1;
            end else begin
                if (mon_we[d] === 1'b1) begin
                    if (wr_n[d] < 64) begin
                        wr_cyc[d][wr_n[d]]  <= cyc;
                        wr_addr[d][wr_n[d]] <= mon_waddr[d];
                        wr_data[d][wr_n[d]] <= mon_wdata[d];
                    end
                    wr_n[d] <= wr_n[d] + 1;
                end
                if (mon_re[d] === 1'b1) begin
                    if (rd_n[d] < 64) begin
                        rd_cyc[d][rd_n[d]]  <= cyc;
                        rd_addr[d][rd_n[d]] <= mon_raddr[d];
                    end
                    rd_n[d] <= rd_n[d] + 1;
                end
                if (mon_we[d] === 1'b1 && mon_re[d] === 1'b1) ovl_n[d] <= ovl_n[d] + 1;
                if (mon_busy[d] === 1'b1) busy_n[d] <= busy_n[d] + 1;
                if (mon_done[d] === 1'b1) begin
                    done_n[d]   <= done_n[d] + 1;
                    done_cyc[d] <= cyc;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        step();
        mon_clr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
        mon_clr = 1'b1;
        repeat (3) step();
        checks++;
        if ({m1.hd_re, m1.im_we, busy1, done1, m1.hd_addr, m1.im_addr, m1.im_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_lat1 got re=%b we=%b busy=%b done=%b ha=%h ia=%h wd=%h, want all 0",
                     m1.hd_re, m1.im_we, busy1, done1, m1.hd_addr, m1.im_addr, m1.im_wdata);
        end
        checks++;
        if ({m3.hd_re, m3.im_we, busy3, done3, m3.hd_addr, m3.im_addr, m3.im_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_lat3 got re=%b we=%b busy=%b done=%b ha=%h ia=%h wd=%h, want all 0",
                     m3.hd_re, m3.im_we, busy3, done3, m3.hd_addr, m3.im_addr, m3.im_wdata);
        end
`ifdef BOOT_COPIER_CHECKSUM_EN
        checks++;
        if (chk1 !== '0 || chk3 !== '0) begin
            errors++;
            $display("FAIL reset_checksum got %h/%h want 0", chk1, chk3);
        end
`endif
        reset = 1'b0;
        mon_clr = 1'b0;
        repeat (3) step();
        checks++;
        if (busy1 !== 1'b0 || busy3 !== 1'b0 || done_n[0] != 0 || rd_n[0] != 0) begin
            errors++;
            $display("FAIL idle_after_reset busy=%b/%b done_n=%0d rd_n=%0d want 0", busy1, busy3, done_n[0], rd_n[0]);
        end
    endtask

    // Full copy on both instances, compared word by word against the model.
    task automatic test_copy(input string name, input addr_t s, input addr_t dd, input len_t n);
        int sc, lat, tmo, wc, rc, nn;
        addr_t ra, wa;
        nn = int'(n);
        clear_mon();
        src_addr = s; dst_addr = dd; len = n; start = 1'b1;
        sc = cyc;
        step();
        start = 1'b0;
        src_addr = addr_t'($urandom); dst_addr = addr_t'($urandom); len = len_t'($urandom_range(1, 8));
        tmo = 0;
        while (done_n[1] == 0 && tmo < nn * 8 + 20) begin
            step();
            tmo++;
        end
        checks++;
        if (done_n[1] == 0) begin
            errors++;
            $display("FAIL %s timeout after %0d cycles, want done", name, tmo);
        end
        repeat (4) step();
        for (int d = 0; d < 2; d++) begin
            lat = (d == 0) ? 1 : 3;
            checks++;
            if (wr_n[d] != nn || rd_n[d] != nn) begin
                errors++;
                $display("FAIL %s_count lat%0d got wr=%0d rd=%0d want %0d", name, lat, wr_n[d], rd_n[d], nn);
            end
            for (int i = 0; i < nn && i < 64 && i < wr_n[d] && i < rd_n[d]; i++) begin
                ra = s + addr_t'(i);
                wa = dd + addr_t'(i);
                rc = sc + 1 + i * (lat + 1);
                wc = rc + lat;
                checks++;
                if (rd_addr[d][i] !== ra || rd_cyc[d][i] != rc) begin
                    errors++;
                    $display("FAIL %s_read lat%0d word %0d got addr=%h cyc=%0d want addr=%h cyc=%0d",
                             name, lat, i, rd_addr[d][i], rd_cyc[d][i] - sc, ra, rc - sc);
                end
                checks++;
                if (wr_addr[d][i] !== wa || wr_data[d][i] !== hd_mem[ra] || wr_cyc[d][i] != wc) begin
                    errors++;
                    $display("FAIL %s_write lat%0d word %0d got addr=%h data=%h cyc=%0d want addr=%h data=%h cyc=%0d",
                             name, lat, i, wr_addr[d][i], wr_data[d][i], wr_cyc[d][i] - sc, wa, hd_mem[ra], wc - sc);
                end
            end
            checks++;
            if (done_n[d] != 1 || done_cyc[d] != sc + nn * (lat + 1) + 1) begin
                errors++;
                $display("FAIL %s_done lat%0d got n=%0d at +%0d want 1 at +%0d",
                         name, lat, done_n[d], done_cyc[d] - sc, nn * (lat + 1) + 1);
            end
            checks++;
            if (busy_n[d] != nn * (lat + 1) || ovl_n[d] != 0) begin
                errors++;
                $display("FAIL %s_busy lat%0d got busy=%0d overlap=%0d want busy=%0d overlap=0",
                         name, lat, busy_n[d], ovl_n[d], nn * (lat + 1));
            end
        end
`ifdef BOOT_COPIER_CHECKSUM_EN
        begin
            logic [DW-1:0] esum;
            esum = '0;
            for (int i = 0; i < nn; i++) esum = esum + hd_mem[s + addr_t'(i)];
            checks++;
            if (chk1 !== esum || chk3 !== esum) begin
                errors++;
                $display("FAIL %s_checksum got %h/%h want %h", name, chk1, chk3, esum);
            end
        end
`endif
    endtask

    task automatic test_start_ignored();
        int sc, t;
        logic pulsed;
        clear_mon();
        src_addr = 12'h100; dst_addr = 12'h300; len = 13'd5; start = 1'b1;
        sc = cyc;
        step();
        pulsed = 1'b0;
        t = 0;
        while (done_n[1] == 0 && t < 200) begin
            start = 1'b0;
            if (t == 2) begin
                start = 1'b1; src_addr = 12'h007; dst_addr = 12'h777; len = 13'd2;
            end else if (done1 === 1'b1 && !pulsed) begin
                start = 1'b1; src_addr = 12'h009; dst_addr = 12'h999; len = 13'd1;
                pulsed = 1'b1;
            end
            step();
            t++;
        end
        start = 1'b0;
        repeat (10) step();
        checks++;
        if (!pulsed || done_n[1] == 0) begin
            errors++;
            $display("FAIL ignore_timeout got pulsed=%b done3=%0d want 1 and 1", pulsed, done_n[1]);
        end
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (wr_n[d] != 5 || done_n[d] != 1) begin
                errors++;
                $display("FAIL ignore_count dut%0d got wr=%0d done=%0d want 5 and 1", d, wr_n[d], done_n[d]);
            end
            for (int i = 0; i < 5 && i < wr_n[d]; i++) begin
                checks++;
                if (wr_addr[d][i] !== 12'h300 + addr_t'(i) || wr_data[d][i] !== hd_mem[12'h100 + addr_t'(i)]) begin
                    errors++;
                    $display("FAIL ignore_write dut%0d word %0d got %h:%h want %h:%h", d, i, wr_addr[d][i],
                             wr_data[d][i], 12'h300 + addr_t'(i), hd_mem[12'h100 + addr_t'(i)]);
                end
            end
        end
        checks++;
        if (done_cyc[0] != sc + 11 || busy_n[0] != 10) begin
            errors++;
            $display("FAIL ignore_timing got done +%0d busy %0d want +11 busy 10", done_cyc[0] - sc, busy_n[0]);
        end
    endtask

    task automatic test_reset_abort();
        int t;
        clear_mon();
        src_addr = 12'h040; dst_addr = 12'h500; len = 13'd6; start = 1'b1;
        step();
        start = 1'b0;
        t = 0;
        while (!(m1.im_we === 1'b1 && wr_n[0] == 1) && t < 50) begin
            step();
            t++;
        end
        checks++;
        if (t >= 50) begin
            errors++;
            $display("FAIL abort_wait got no second write in %0d cycles, want one", t);
        end
        reset = 1'b1;
        step();
        checks++;
        if ({m1.im_we, busy1, done1, m1.im_wdata} !== '0 || {m3.im_we, m3.hd_re, busy3, done3} !== '0) begin
            errors++;
            $display("FAIL abort_outputs got we=%b busy=%b done=%b / we=%b re=%b busy=%b done=%b want all 0",
                     m1.im_we, busy1, done1, m3.im_we, m3.hd_re, busy3, done3);
        end
        reset = 1'b0;
        repeat (40) step();
        checks++;
        if (done_n[0] != 0 || done_n[1] != 0 || wr_n[0] != 2 || busy1 !== 1'b0 || busy3 !== 1'b0) begin
            errors++;
            $display("FAIL abort_after got done=%0d/%0d wr=%0d busy=%b/%b want 0/0 2 0/0",
                     done_n[0], done_n[1], wr_n[0], busy1, busy3);
        end
    endtask

`ifdef BOOT_COPIER_CHECKSUM_EN
    task automatic test_checksum();
        hd_mem[12'h020] = 32'h0000_0001;
        hd_mem[12'h021] = 32'h0000_0002;
        hd_mem[12'h022] = 32'hFFFF_FFFF;
        test_copy("checksum", 12'h020, 12'h600, 13'd3);
        checks++;
        if (chk1 !== 32'h0000_0002) begin
            errors++;
            $display("FAIL checksum_const got %h want 00000002", chk1);
        end
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) hd_mem[i] = $urandom;
        test_reset();
        for (int i = 0; i < 4; i++) hd_mem[12'h010 + i] = 32'hA0 + i;
        test_copy("plan", 12'h010, 12'h200, 13'd4);
        test_copy("len0", 12'h123, 12'h456, 13'd0);
        test_copy("wrap", 12'hFFE, 12'hFFF, 13'd3);
        for (int k = 0; k < 8; k++)
            test_copy("random", addr_t'($urandom), addr_t'($urandom), len_t'($urandom_range(1, 20)));
        test_start_ignored();
        test_reset_abort();
        test_copy("after_reset", 12'h080, 12'h0F0, 13'd3);
`ifdef BOOT_COPIER_CHECKSUM_EN
        test_checksum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/boot_copier.md
Name: boot_copier

Overview:
- DMA-style copier that moves a program image from the hard-disk model into instruction memory during boot.
- Sits directly downstream of the BIOS instruction controller.
- The CPU glue derives a one-cycle `start` pulse from the controller's CKIM flag. `busy` stalls BIOS fetch until the copy completes.
- Once the image is in memory, the BIOS HALT hands control to the memory instruction stream.

Parameters:
- ADDR_W, 12, address width of both HD and instruction memory (word addresses).
- DATA_W, 32, word width.
- HD_RD_LAT, 1, cycles from `hd_re` to valid `hd_rdata`. Legal range is 1..7.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- src_addr  in  ADDR_W  first HD word address.
- dst_addr  in  ADDR_W  first instruction-memory word address.
- len  in  ADDR_W+1  number of words to copy (0..2^ADDR_W).
- hd_re  out  1  HD read strobe.
- hd_addr  out  ADDR_W  HD read address.
- hd_rdata  in  DATA_W  HD read data.
- im_we  out  1  instruction-memory write enable.
- im_addr  out  ADDR_W  instruction-memory write address.
- im_wdata  out  DATA_W  instruction-memory write data.
- busy  out  1  high from the cycle after an accepted start until DONE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: on a clocked `reset`, all of the following go to 0 and state becomes IDLE:
  - `hd_re`, `im_we`, `busy`, `done`
  - `hd_addr`, `im_addr`, `im_wdata`
  - internal index and latency counter
- Reset mid-copy aborts immediately. No further writes occur and no `done` pulse is generated.
- FSM states: IDLE, READ, WAIT, WRITE, DONE. Outputs are registered.
- IDLE:
  - `start` latches `src_addr`, `dst_addr` and `len`, and clears `idx`.
  - If `len==0`, go to DONE. Otherwise go to READ.
  - `start` outside IDLE is ignored, with no queuing.
- READ (1 cycle):
  - Drive `hd_re=1` and `hd_addr=src+idx`.
  - Go to WRITE if `HD_RD_LAT==1`. Otherwise go to WAIT with the latency counter set to `HD_RD_LAT-1`.
- WAIT:
  - `hd_re=0`; decrement the counter.
  - Go to WRITE when the counter reaches 1.
  - WAIT lasts exactly `HD_RD_LAT-1` cycles.
- WRITE (1 cycle):
  - Drive `im_we=1`, `im_addr=dst+idx`, `im_wdata=hd_rdata`, with `hd_rdata` sampled this cycle.
  - Increment `idx`.
  - Go to DONE if `idx+1==len`. Otherwise go to READ.
- DONE (1 cycle): `done=1`, `busy=0`, then go to IDLE. A `start` on the DONE cycle is ignored.
- Throughput: each word takes `HD_RD_LAT+1` cycles. Total latency from the start cycle to `done` is `len*(HD_RD_LAT+1)+1` cycles.
- Address arithmetic is modulo `2^ADDR_W`, so `src+idx` and `dst+idx` wrap silently. `len=2^ADDR_W` copies the full space.
- `busy` is 1 in READ, WAIT and WRITE, and 0 in IDLE and DONE.
- `im_we` and `hd_re` are never high in the same cycle.

Optional Feature:
- Macro: BOOT_COPIER_CHECKSUM_EN.
- When defined:
  - Add output port `checksum [DATA_W-1:0]`.
  - The running 32-bit modular sum of every written `im_wdata` is cleared on accepted `start` and on `reset`.
  - The value is stable and valid from the `done` cycle until the next accepted `start`.
- When undefined: the port and the adder are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package `boot_pkg` holds:
  - the FSM state enum `boot_state_t`
  - BIOS opcode constants HALT=6'b011000, CKHD=6'b011101, CKIM=6'b011110, CKDM=6'b011111, shared with the BIOS controller
  - default ADDR_W and DATA_W
- One natural sub-module: `rd_latency_counter`, a loadable 3-bit down-counter with a `zero` flag, used for WAIT.

Test Plan:
- Copy, LAT=1: HD[0x10..0x13] = 0xA0,0xA1,0xA2,0xA3; start with src=0x10, dst=0x200, len=4 -> `im_we` pulses at addresses 0x200..0x203 with matching data, 2 cycles per word, `done` 9 cycles after start, `busy` high for 8 cycles.
- Copy, LAT=3: same stimulus -> 4 cycles per word, `done` 17 cycles after start, `hd_re`/`im_we` never overlap.
- len=0: start -> no `hd_re`/`im_we`, `done` pulses on the next cycle, `busy` never rises.
- Wrap: src=0xFFE, dst=0xFFF, len=3 -> reads 0xFFE,0xFFF,0x000, writes 0xFFF,0x000,0x001.
- Start while busy, then reset: a second start mid-copy has no effect on addresses or len. `reset` asserted during the 2nd WRITE leaves `im_we`, `busy` and `done` all 0 next cycle; no `done` ever fires; a subsequent start works normally.
- Checksum (macro on): copy words 1,2,0xFFFFFFFF -> `checksum`=0x00000002 at `done`.
